// File: rtl/siggen_pkg.sv
// Shared types and default widths for the signal-generator datapath blocks.
package siggen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } dl_state_t;

  localparam int DEF_ADDRESS_WIDTH = 9;
  localparam int DEF_DATA_WIDTH    = 8;

endpackage

// File: rtl/delay_line_ctrl.sv
// Write-side controller for the delay-line sample RAM: circular write pointer,
// trailing read at a latched distance, and a registered delayed output stream.
module delay_line_ctrl
  import siggen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     wr,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    din,
  output logic                     rd,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     filled
);

  localparam int                 DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FULL = (ADDRESS_WIDTH + 1)'(DEPTH);

  dl_state_t r_state;
  dl_state_t w_state_next;

  logic [ADDRESS_WIDTH-1:0] r_wptr;
  logic [ADDRESS_WIDTH-1:0] r_dly_q;
  logic [ADDRESS_WIDTH:0]   r_fill_cnt;
  logic [ADDRESS_WIDTH:0]   w_fill_cnt_next;
  logic [ADDRESS_WIDTH:0]   w_dly_eff;
  logic                     w_accept;
  logic                     w_zero;

  logic                     r_wr;
  logic                     r_rd;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [ADDRESS_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0]    r_din;
  logic                     r_zero_s1;
  logic                     r_vld_s2;
  logic                     r_zero_s2;
  logic                     r_out_valid;
  logic [DATA_WIDTH-1:0]    r_out_data;

  // A latched delay of 0 stands for the whole ring.
  always_comb begin
    w_dly_eff = (r_dly_q == '0) ? FULL : {1'b0, r_dly_q};
    w_accept  = in_valid && en && (r_state != IDLE);
    w_zero    = (r_fill_cnt < w_dly_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fill_cnt_next = r_fill_cnt;
    if (w_accept && (r_fill_cnt != FULL)) begin
      w_fill_cnt_next = r_fill_cnt + 1'b1;
    end
    case (r_state)
      IDLE: begin
        w_fill_cnt_next = '0;
        if (en) begin
          w_state_next = FILL;
        end
      end
      FILL: begin
        if (!en) begin
          w_state_next    = IDLE;
          w_fill_cnt_next = '0;
        end else if (w_fill_cnt_next >= w_dly_eff) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          w_state_next    = IDLE;
          w_fill_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_fill_cnt_next = '0;
      end
    endcase
  end

  // Request stage: one RAM write and its trailing read per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_dly_q    <= '0;
      r_fill_cnt <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_din      <= '0;
      r_zero_s1  <= 1'b0;
    end else begin
      r_fill_cnt <= w_fill_cnt_next;
      r_wr       <= w_accept;
      r_rd       <= w_accept;
      r_zero_s1  <= w_zero;
      if ((r_state == IDLE) && en) begin
        r_dly_q <= offset;
      end
      if (w_accept) begin
        r_wr_addr <= r_wptr;
        r_rd_addr <= r_wptr - r_dly_q;
        r_din     <= in_data;
        r_wptr    <= r_wptr + 1'b1;
      end
    end
  end

  // RAM data arrives one cycle after the read; the fill decision rides along.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_s2    <= 1'b0;
      r_zero_s2   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_vld_s2    <= r_rd;
      r_zero_s2   <= r_zero_s1;
      r_out_valid <= r_vld_s2;
      if (r_vld_s2) begin
        r_out_data <= r_zero_s2 ? '0 : ram_dout;
      end
    end
  end

  assign wr        = r_wr;
  assign rd        = r_rd;
  assign wr_addr   = r_wr_addr;
  assign rd_addr   = r_rd_addr;
  assign din       = r_din;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign filled    = (r_state == RUN);

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: directed scenarios plus random traffic, checked
// every cycle against a sample-history model with a RAM model alongside.
module tb_delay_line_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] offset = '0;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] din;
  logic          rd;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ram_dout;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          filled;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .offset(offset), .wr(wr), .wr_addr(wr_addr), .din(din), .rd(rd),
    .rd_addr(rd_addr), .ram_dout(ram_dout), .out_valid(out_valid),
    .out_data(out_data), .filled(filled)
  );

  // Synchronous RAM, read-before-write on a shared address.
  logic [DW-1:0] ram [16];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (rd) ram_dout <= ram[rd_addr];
    if (wr) ram[wr_addr] <= din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, indexed by cycle number.
  int          cyc = 0;
  bit          exp_wr  [NC];
  bit [AW-1:0] exp_wa  [NC];
  bit [AW-1:0] exp_ra  [NC];
  bit [DW-1:0] exp_din [NC];
  bit          exp_ov  [NC];
  bit [DW-1:0] exp_od  [NC];
  bit          exp_fl  [NC];

  // Model: accepted samples go into a history ring; each output is the sample
  // D places back, or 0 while fewer than D samples have been taken this run.
  bit          m_active = 1'b0;
  int          m_wptr = 0;
  int          m_cnt = 0;
  int          m_dly = 0;
  int          m_d;
  int          m_c;
  bit [DW-1:0] mem_m [16];

  always @(posedge clk) begin
    m_c = cyc;
    if (rst) begin
      m_active = 1'b0;
      m_wptr = 0;
      m_cnt = 0;
      m_dly = 0;
      for (int k = 1; k <= 3; k++) begin
        exp_wr[m_c + k] = 1'b0;
        exp_ov[m_c + k] = 1'b0;
      end
    end else if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_dly = int'(offset);
        m_cnt = 0;
      end
    end else if (!en) begin
      m_active = 1'b0;
      m_cnt = 0;
    end else if (in_valid) begin
      m_d = (m_dly == 0) ? 16 : m_dly;
      exp_wr[m_c + 1]  = 1'b1;
      exp_wa[m_c + 1]  = AW'(m_wptr);
      exp_ra[m_c + 1]  = AW'((m_wptr - m_dly) & 15);
      exp_din[m_c + 1] = in_data;
      exp_ov[m_c + 3]  = 1'b1;
      exp_od[m_c + 3]  = (m_cnt < m_d) ? '0 : mem_m[(m_wptr - m_d) & 15];
      mem_m[m_wptr] = in_data;
      m_wptr = (m_wptr + 1) % 16;
      if (m_cnt < 16) m_cnt++;
    end
    m_d = (m_dly == 0) ? 16 : m_dly;
    exp_fl[m_c + 1] = m_active && (m_cnt >= m_d);
    cyc = m_c + 1;
  end

  // Compare process, sampling just after each rising edge; also captures
  // streams for the directed scenarios.
  logic [DW-1:0] cap_out [$];
  int            cap_ovc [$];
  logic [AW-1:0] cap_wa  [$];
  logic [AW-1:0] cap_ra  [$];

  always begin
    @(posedge clk);
    #1;
    if (cyc >= 1) begin
      chk("wr", wr, exp_wr[cyc]);
      chk("rd", rd, exp_wr[cyc]);
      if (exp_wr[cyc]) begin
        chk("wr_addr", wr_addr, exp_wa[cyc]);
        chk("rd_addr", rd_addr, exp_ra[cyc]);
        chk("din", din, exp_din[cyc]);
      end
      chk("out_valid", out_valid, exp_ov[cyc]);
      if (exp_ov[cyc]) chk("out_data", out_data, exp_od[cyc]);
      chk("filled", filled, exp_fl[cyc]);
      if (out_valid === 1'b1) begin
        cap_out.push_back(out_data);
        cap_ovc.push_back(cyc);
      end
      if (wr === 1'b1) begin
        cap_wa.push_back(wr_addr);
        cap_ra.push_back(rd_addr);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_caps();
    cap_out.delete();
    cap_ovc.delete();
    cap_wa.delete();
    cap_ra.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_filled"}, filled, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  logic [DW-1:0] exp1 [10] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  int s1_cyc;
  int n_ov;

  initial begin
    tick();

    // Delay 3, samples 1..10 back to back.
    do_reset();
    en = 1'b1;
    offset = 4'd3;
    tick();
    clear_caps();
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) s1_cyc = cyc;
      send(DW'(i));
      if (i == 2) chk("s1_filled_after_2", filled, 0);
      if (i == 3) chk("s1_filled_after_3", filled, 1);
    end
    idle(5);
    chk("s1_count", cap_out.size(), 10);
    for (int i = 0; i < 10 && i < cap_out.size(); i++) chk("s1_out", cap_out[i], exp1[i]);
    if (cap_ovc.size() > 0) chk("s1_latency", cap_ovc[0] - s1_cyc, 3);

    // Full depth: old data on read-during-write.
    do_reset();
    en = 1'b1;
    offset = 4'd0;
    tick();
    clear_caps();
    for (int k = 0; k < 40; k++) send(DW'(8'h10 + k));
    idle(5);
    chk("s2_count", cap_out.size(), 40);
    for (int k = 0; k < 40 && k < cap_out.size(); k++)
      chk("s2_out", cap_out[k], (k < 16) ? 0 : 8'h10 + k - 16);

    // Wrap-around with delay 5.
    do_reset();
    en = 1'b1;
    offset = 4'd5;
    tick();
    clear_caps();
    for (int k = 0; k < 20; k++) send(DW'($urandom));
    idle(5);
    chk("s3_count", cap_wa.size(), 20);
    for (int k = 0; k < 20 && k < cap_wa.size(); k++) begin
      chk("s3_wr_addr", cap_wa[k], k % 16);
      chk("s3_rd_addr", cap_ra[k], (k + 11) % 16);
    end
    if (cap_ra.size() > 16) chk("s3_rd_addr_at_wrap", cap_ra[16], 11);

    // Gapped input, delay 2.
    do_reset();
    en = 1'b1;
    offset = 4'd2;
    tick();
    for (int k = 0; k < 15; k++) begin
      send(DW'($urandom));
      in_data = DW'($urandom);
      idle(2);
    end
    idle(4);

    // Offset change mid-run is ignored; en low then high relatches it.
    do_reset();
    en = 1'b1;
    offset = 4'd3;
    tick();
    for (int k = 0; k < 8; k++) send(DW'($urandom));
    offset = 4'd7;
    for (int k = 0; k < 6; k++) send(DW'($urandom));
    en = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    en = 1'b1;
    tick();
    clear_caps();
    for (int k = 1; k <= 12; k++) begin
      send(DW'($urandom));
      if (k == 6) chk("s5_filled_after_6", filled, 0);
      if (k == 7) chk("s5_filled_after_7", filled, 1);
    end
    idle(5);
    if (cap_wa.size() > 0) chk("s5_wptr_retained", cap_wa[0], 14);
    chk("s5_count", cap_out.size(), 12);

    // Reset kills samples in flight.
    do_reset();
    en = 1'b1;
    offset = 4'd1;
    tick();
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    rst = 1'b1;
    en = 1'b0;
    tick();
    check_all_zero("s6_after_rst");
    rst = 1'b0;
    n_ov = cap_out.size();
    clear_caps();
    idle(6);
    chk("s6_no_out_after_rst", cap_out.size(), 0);

    // Random traffic with enable toggles, offset churn and rare resets.
    do_reset();
    en = 1'b1;
    for (int t = 0; t < 900; t++) begin
      if ($urandom_range(0, 24) == 0) en = ~en;
      offset = AW'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = DW'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    en = 1'b0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
